// File: rtl/option_fifo_pkg.sv
// option_fifo_pkg: shared defaults and helpers for the nonogram option queue.
//   DefaultSize  : board side, also the option payload width
//   DefaultDepth : queue entries (power of two)
//   line_w()     : width of a line-index header for a given board side
//   wr_src_e     : which source owns the single write slot in a cycle
package option_fifo_pkg;

  localparam int unsigned DefaultSize  = 3;
  localparam int unsigned DefaultDepth = 64;

  // A board of side N has N rows plus N columns to index.
  function automatic int unsigned line_w(input int unsigned size);
    return $clog2(2 * size);
  endfunction

  typedef enum logic [1:0] {
    SrcNone,
    SrcPb,
    SrcLoad
  } wr_src_e;

endpackage

// File: rtl/option_fifo_ram.sv
// option_fifo_ram: simple dual-port storage for the option queue.
// One write port, one read port with a registered read (block-RAM style).
//   clk_i   : clock
//   we_i    : write enable;  waddr_i / wdata_i : write address / data
//   re_i    : read enable;   raddr_i           : read address
//   rdata_o : read data, updated only on the edge after re_i, held otherwise
module option_fifo_ram #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/option_fifo.sv
// option_fifo: circular work queue feeding the nonogram solver.
// Entries are {is_header, payload}; a header carries a line index zero-extended to SIZE bits.
//   clk, rst                   : clock, synchronous active-high reset
//   load_valid/is_header/data  : loader offer; accepted when load_valid & load_ready
//   load_ready                 : !full & !pb_valid (put-back wins the write slot)
//   pb_valid/is_header/data    : solver put-back pulse; dropped (overflow) when no room
//   valid_out/out_is_header/out_data : first-word-fall-through head entry
//   pop                        : consume head (ignored when !valid_out)
//   count                      : occupancy including the presented head
//   idle                       : empty and nothing offered this cycle
//   overflow                   : sticky, a put-back was dropped
module option_fifo
  import option_fifo_pkg::*;
#(
  parameter int unsigned SIZE   = DefaultSize,
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned LINE_W = line_w(SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic                   load_is_header,
  input  logic [SIZE-1:0]        load_data,
  output logic                   load_ready,
  input  logic                   pb_valid,
  input  logic                   pb_is_header,
  input  logic [SIZE-1:0]        pb_data,
  output logic                   valid_out,
  output logic                   out_is_header,
  output logic [SIZE-1:0]        out_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle,
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (SIZE < LINE_W) begin : g_size_chk
    $error("option_fifo: SIZE must be >= LINE_W");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("option_fifo: DEPTH must be a power of two >= 4");
  end

  typedef struct packed {
    logic            is_header;
    logic [SIZE-1:0] payload;
  } entry_t;

  function automatic entry_t mk_entry(input logic hdr, input logic [SIZE-1:0] d);
    entry_t e;
    e.is_header = hdr;
    e.payload   = d;
    if (hdr) begin
      e.payload              = '0;
      e.payload[LINE_W-1:0] = d[LINE_W-1:0];
    end
    return e;
  endfunction

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            valid_out_q, valid_out_d;
  // Head source: 1 = RAM read register, 0 = bypass register.
  logic            src_ram_q, src_ram_d;
  entry_t          byp_q, byp_d;
  logic            overflow_q, overflow_d;

  wr_src_e wr_src;
  entry_t  wr_entry, ram_rdata, head;
  logic    full, pop_ok, wr_en, advance, ram_empty, ram_we, ram_re;

  always_comb begin
    pop_ok    = pop & valid_out_q;
    full      = (count_q == CntW'(DEPTH));
    // Entries stored in RAM = count minus the one held in the head slot.
    ram_empty = (count_q == CntW'(valid_out_q));
    advance   = !valid_out_q || pop_ok;

    wr_src = SrcNone;
    if (pb_valid) begin
      if (!full || pop_ok) wr_src = SrcPb;
    end else if (load_valid && !full) begin
      wr_src = SrcLoad;
    end
    wr_en    = (wr_src != SrcNone);
    wr_entry = (wr_src == SrcPb) ? mk_entry(pb_is_header, pb_data)
                                 : mk_entry(load_is_header, load_data);

    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    valid_out_d = valid_out_q;
    src_ram_d   = src_ram_q;
    byp_d       = byp_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    if (advance && !ram_empty) begin
      ram_re      = 1'b1;
      rd_ptr_d    = rd_ptr_q + PtrW'(1);
      valid_out_d = 1'b1;
      src_ram_d   = 1'b1;
      ram_we      = wr_en;
    end else if (advance) begin
      // Nothing buffered: a write lands straight in the head slot.
      valid_out_d = wr_en;
      if (wr_en) begin
        byp_d     = wr_entry;
        src_ram_d = 1'b0;
      end
    end else begin
      ram_we = wr_en;
    end
    if (ram_we) wr_ptr_d = wr_ptr_q + PtrW'(1);

    count_d    = count_q + CntW'(wr_en) - CntW'(pop_ok);
    overflow_d = overflow_q | (pb_valid & (wr_src != SrcPb));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_out_q <= 1'b0;
      src_ram_q   <= 1'b0;
      byp_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_out_q <= valid_out_d;
      src_ram_q   <= src_ram_d;
      byp_q       <= byp_d;
      overflow_q  <= overflow_d;
    end
  end

  option_fifo_ram #(
    .Width($bits(entry_t)),
    .Depth(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_entry),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  assign head          = src_ram_q ? ram_rdata : byp_q;
  assign valid_out     = valid_out_q;
  assign out_is_header = head.is_header;
  assign out_data      = head.payload;
  assign count         = count_q;
  assign load_ready    = !full && !pb_valid;
  assign idle          = (count_q == '0) && !load_valid && !pb_valid;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_option_fifo.sv
module tb_option_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_is_header, pb_valid, pb_is_header, pop;
  logic [2:0] load_data, pb_data;
  logic       load_ready, valid_out, out_is_header, idle, overflow;
  logic [2:0] out_data;
  logic [6:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side model of the queue as the specification describes it.
  logic [3:0] exp_q[$];
  int         mcount = 0;
  logic       movf   = 1'b0;

  option_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_is_header(load_is_header),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .pb_valid      (pb_valid),
    .pb_is_header  (pb_is_header),
    .pb_data       (pb_data),
    .valid_out     (valid_out),
    .out_is_header (out_is_header),
    .out_data      (out_data),
    .pop           (pop),
    .count         (count),
    .idle          (idle),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed head must match the oldest accepted entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid_out === 1'b1 && pop === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %0h expected nothing queued", {out_is_header, out_data});
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({out_is_header, out_data} !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h at %0t",
                   {out_is_header, out_data}, e, $time);
        end
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input logic lv, input logic lh, input logic [2:0] ld,
                      input logic pv, input logic ph, input logic [2:0] pd, input logic p);
    logic full, pop_ok, pb_acc, ld_acc;
    load_valid = lv; load_is_header = lh; load_data = ld;
    pb_valid = pv; pb_is_header = ph; pb_data = pd; pop = p;
    #1;
    full   = (mcount == 64);
    pop_ok = p && (mcount != 0);
    check("load_ready", 32'(load_ready), 32'(!full && !pv));
    check("idle", 32'(idle), 32'(mcount == 0 && !lv && !pv));
    if (!rst) begin
      pb_acc = pv && (!full || pop_ok);
      ld_acc = lv && !pv && !full;
      if (pb_acc) exp_q.push_back({ph, pd});
      else if (ld_acc) exp_q.push_back({lh, ld});
      mcount = mcount + ((pb_acc || ld_acc) ? 1 : 0) - (pop_ok ? 1 : 0);
      if (pv && !pb_acc) movf = 1'b1;
    end else begin
      mcount = 0;
      movf   = 1'b0;
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), mcount);
    check("valid_out", 32'(valid_out), 32'(mcount != 0));
    check("overflow", 32'(overflow), 32'(movf));
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] h;
    rst = 1'b1;
    load_valid = 0; load_is_header = 0; load_data = 0;
    pb_valid = 0; pb_is_header = 0; pb_data = 0; pop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_hdr", 32'(out_is_header), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_load_ready", 32'(load_ready), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_idle", 32'(idle), 1);

    // Header then two options, no pop.
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 3'b101, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 3'd0, 1'b0);
    nop();
    check("t1_count", 32'(count), 3);
    check("t1_valid", 32'(valid_out), 1);
    check("t1_hdr", 32'(out_is_header), 1);
    check("t1_data", 32'(out_data), 32'(3'b010));
    repeat (3) do_pop();
    nop();
    check("t1_drained", 32'(valid_out), 0);

    // Fill through the loader.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, (i % 8) == 0, 3'(i % 8), 1'b0, 1'b0, 3'd0, 1'b0);
    end
    check("fill_count", 32'(count), 64);
    repeat (3) step(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
    check("full_load_ready", 32'(load_ready), 0);
    check("full_count_held", 32'(count), 64);
    step(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0, 1'b1);
    check("after_pop_count", 32'(count), 63);
    step(1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0);
    check("one_load_count", 32'(count), 64);

    // Full: put-back with same-cycle pop is accepted.
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'b110, 1'b1);
    check("pb_pop_count", 32'(count), 64);
    check("pb_pop_ovf", 32'(overflow), 0);

    // Full: put-back without pop is dropped.
    h = exp_q[0];
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b101, 1'b0);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_count", 32'(count), 64);
    check("drop_head", 32'({out_is_header, out_data}), 32'(h));
    nop();
    check("ovf_sticky", 32'(overflow), 1);

    // Drain everything; monitor checks the order.
    for (int i = 0; i < 70 && mcount > 0; i++) do_pop();
    nop();
    check("drain_valid", 32'(valid_out), 0);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // Put-back and load in the same cycle: put-back wins, load follows.
    step(1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 3'b100, 1'b0);
    step(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0);
    nop();
    check("arb_count", 32'(count), 2);
    check("arb_head_hdr", 32'(out_is_header), 1);
    check("arb_head_data", 32'(out_data), 32'(3'b100));
    repeat (2) do_pop();
    nop();

    // Sustained push/pop at ~5 entries across pointer wraps.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'(i), 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, (i % 5) == 0, 3'((i * 3) % 8), 1'b0, 1'b0, 3'd0, 1'b1);
    end
    check("wrap_count", 32'(count), 5);

    // Reset mid-stream.
    rst = 1'b1;
    nop();
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_out), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_idle", 32'(idle), 1);
    check("midrst_ovf", 32'(overflow), 0);
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
